// File: rtl/cpc_rom_bootloader_pkg.sv
// cpc_rom_bootloader_pkg: boot loader state encodings and default ROM image geometry
package cpc_rom_bootloader_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, GAP, DONE} state_t;
  localparam int DEF_ROM_BYTES = 49152;
  localparam int unsigned DEF_BASE_ADDR = 0;
endpackage

// File: rtl/cpc_rom_bootloader.sv
// cpc_rom_bootloader: streams 32-bit host boot words into the SRAM ROM area byte by byte
module cpc_rom_bootloader
  import cpc_rom_bootloader_pkg::*;
#(
  parameter int ADDR_W = 19,
  parameter int unsigned BASE_ADDR = DEF_BASE_ADDR,
  parameter int ROM_BYTES = DEF_ROM_BYTES,
  parameter int WR_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       host_bootdata,
  input  logic              host_bootdata_req,
  output logic              host_bootdata_ack,
  output logic [ADDR_W-1:0] romwrite_addr,
  output logic [7:0]        romwrite_data,
  output logic              romwrite_wr,
  output logic              rom_initialised
);
  localparam int CW = $clog2(ROM_BYTES + 1);
  localparam int WCW = WR_CYCLES > 1 ? $clog2(WR_CYCLES) : 1;
  state_t state, state_n;
  logic [31:0] word;
  logic [1:0] byte_idx, idx_n;
  logic [CW-1:0] count, count_inc;
  logic [WCW-1:0] wr_cnt;
  logic take, last_wr;
  // Words arriving after DONE are still acked so the host never stalls
  always_comb begin
    take = (state == IDLE || state == DONE) && host_bootdata_req && !host_bootdata_ack;
    last_wr = wr_cnt == WCW'(WR_CYCLES - 1);
    count_inc = count + 1'b1;
    idx_n = byte_idx + 2'd1;
    state_n = state;
    case (state)
      IDLE:    state_n = take ? WRITE : IDLE;
      WRITE:   state_n = last_wr ? GAP : WRITE;
      GAP:     state_n = count_inc == CW'(ROM_BYTES) ? DONE : byte_idx == 2'd3 ? IDLE : WRITE;
      default: state_n = DONE;
    endcase
  end
  // addr/data only move in GAP or on capture, so they are stable across every wr pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      host_bootdata_ack <= 1'b0;
      romwrite_wr <= 1'b0;
      romwrite_addr <= ADDR_W'(BASE_ADDR);
      romwrite_data <= 8'd0;
      byte_idx <= 2'd0;
      count <= '0;
      wr_cnt <= '0;
      word <= '0;
      rom_initialised <= 1'b0;
    end else begin
      state <= state_n;
      host_bootdata_ack <= host_bootdata_req && (host_bootdata_ack || take);
      case (state)
        IDLE: if (take) begin
          word <= host_bootdata;
          romwrite_data <= host_bootdata[7:0];
          byte_idx <= 2'd0;
          romwrite_wr <= 1'b1;
          wr_cnt <= '0;
        end
        WRITE: begin
          wr_cnt <= wr_cnt + 1'b1;
          romwrite_wr <= !last_wr;
        end
        GAP: begin
          romwrite_addr <= romwrite_addr + 1'b1;
          count <= count_inc;
          rom_initialised <= state_n == DONE;
          if (state_n == WRITE) begin
            byte_idx <= idx_n;
            romwrite_data <= word[{idx_n, 3'b000} +: 8];
            romwrite_wr <= 1'b1;
            wr_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cpc_rom_bootloader.sv
// tb_cpc_rom_bootloader: directed and randomized checks of the ROM boot loader against a byte-level model
module tb_cpc_rom_bootloader;
  typedef struct {
    logic [18:0] a;
    logic [7:0]  d;
    int          n;
  } wr_t;
  logic clk, reset;
  logic [31:0] dat_ab, dat_c;
  logic req_ab, req_c;
  logic ack[3], wr[3], init[3];
  logic [18:0] addr[3];
  logic [7:0] data[3];
  int checks = 0, failures = 0;
  wr_t wq0[$], wq1[$], wq2[$];
  logic pw[3];
  logic [18:0] pa[3];
  logic [7:0] pd[3];
  int rl[3];
  logic [7:0] img[40];

  cpc_rom_bootloader #(.ROM_BYTES(8), .WR_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .host_bootdata(dat_ab), .host_bootdata_req(req_ab),
    .host_bootdata_ack(ack[0]), .romwrite_addr(addr[0]), .romwrite_data(data[0]),
    .romwrite_wr(wr[0]), .rom_initialised(init[0]));
  cpc_rom_bootloader #(.ROM_BYTES(6), .WR_CYCLES(2)) dut_b (
    .clk(clk), .reset(reset), .host_bootdata(dat_ab), .host_bootdata_req(req_ab),
    .host_bootdata_ack(ack[1]), .romwrite_addr(addr[1]), .romwrite_data(data[1]),
    .romwrite_wr(wr[1]), .rom_initialised(init[1]));
  cpc_rom_bootloader #(.ROM_BYTES(37), .WR_CYCLES(3), .BASE_ADDR(32'h7FFF0)) dut_c (
    .clk(clk), .reset(reset), .host_bootdata(dat_c), .host_bootdata_req(req_c),
    .host_bootdata_ack(ack[2]), .romwrite_addr(addr[2]), .romwrite_data(data[2]),
    .romwrite_wr(wr[2]), .rom_initialised(init[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Records each completed write pulse as (addr, data, pulse length) and checks stability while wr=1
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (wr[k] && pw[k]) begin
        checks++;
        assert (addr[k] === pa[k] && data[k] === pd[k]) else begin
          failures++;
          $error("FAIL stable%0d observed=%h/%h expected=%h/%h", k, addr[k], data[k], pa[k], pd[k]);
        end
        rl[k]++;
      end else if (wr[k]) rl[k] = 1;
      else if (pw[k]) begin
        if (k == 0) wq0.push_back('{pa[k], pd[k], rl[k]});
        else if (k == 1) wq1.push_back('{pa[k], pd[k], rl[k]});
        else wq2.push_back('{pa[k], pd[k], rl[k]});
      end
      pw[k] = wr[k];
      pa[k] = addr[k];
      pd[k] = data[k];
    end
  end

  function automatic int qsize(input int k);
    return k == 0 ? wq0.size() : k == 1 ? wq1.size() : wq2.size();
  endfunction

  task automatic expect_wr(input int k, input int j, input int a, input int d, input int n);
    wr_t e;
    chk($sformatf("wr%0d_%0d_present", k, j), 32'(j < qsize(k)), 1);
    if (j < qsize(k)) begin
      if (k == 0) e = wq0[j];
      else if (k == 1) e = wq1[j];
      else e = wq2[j];
      chk($sformatf("wr%0d_%0d_addr", k, j), 32'(e.a), a);
      chk($sformatf("wr%0d_%0d_data", k, j), 32'(e.d), d);
      chk($sformatf("wr%0d_%0d_len", k, j), e.n, n);
    end
  endtask

  task automatic wait_ack(input int k, input logic v, input int bound, input string tag);
    int n = 0;
    while (ack[k] !== v && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(ack[k]), 32'(v));
  endtask

  initial begin
    int falls;
    logic p, found;
    for (int k = 0; k < 3; k++) begin
      pw[k] = 1'b0;
      pa[k] = '0;
      pd[k] = '0;
      rl[k] = 0;
    end
    reset = 1'b1;
    req_ab = 1'b1;
    req_c = 1'b1;
    dat_ab = 32'hCAFEF00D;
    dat_c = 32'h12345678;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ack", 32'(ack[0]), 0);
      chk("rst_wr", 32'(wr[0]), 0);
    end
    chk("rst_addr_a", 32'(addr[0]), 0);
    chk("rst_addr_c", 32'(addr[2]), 32'h7FFF0);
    chk("rst_data", 32'(data[0]), 0);
    chk("rst_init", 32'(init[0]), 0);
    chk("rst_ack_c", 32'(ack[2]), 0);
    req_ab = 1'b0;
    req_c = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    dat_ab = 32'h44332211;
    req_ab = 1'b1;
    @(negedge clk);
    chk("cap_ack", 32'(ack[0]), 1);
    chk("cap_wr", 32'(wr[0]), 1);
    chk("cap_data", 32'(data[0]), 32'h11);
    chk("cap_addr", 32'(addr[0]), 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_ack", 32'(ack[0]), 1);
    end
    chk("w1_count", qsize(0), 4);
    for (int j = 0; j < 4; j++) expect_wr(0, j, j, 'h11 * (j + 1), 2);
    req_ab = 1'b0;
    @(negedge clk);
    chk("drop_ack", 32'(ack[0]), 0);

    dat_ab = 32'h88776655;
    req_ab = 1'b1;
    p = 1'b0;
    falls = 0;
    for (int i = 0; i < 60 && falls < 4; i++) begin
      @(negedge clk);
      if (p && !wr[0]) begin
        falls++;
        if (falls == 2) begin
          chk("b_init_pre", 32'(init[1]), 0);
          @(negedge clk);
          chk("b_init", 32'(init[1]), 1);
        end
        if (falls == 4) begin
          chk("a_init_pre", 32'(init[0]), 0);
          @(negedge clk);
          chk("a_init", 32'(init[0]), 1);
        end
      end
      p = wr[0];
    end
    chk("w2_falls", falls, 4);
    repeat (3) @(negedge clk);
    chk("a_count", qsize(0), 8);
    for (int j = 4; j < 8; j++) expect_wr(0, j, j, 'h11 * (j + 1), 2);
    chk("b_count", qsize(1), 6);
    for (int j = 0; j < 6; j++) expect_wr(1, j, j, 'h11 * (j + 1), 2);
    req_ab = 1'b0;
    @(negedge clk);
    chk("w2_drop_ack", 32'(ack[0]), 0);

    dat_ab = 32'hDEADBEEF;
    req_ab = 1'b1;
    @(negedge clk);
    chk("done_ack_a", 32'(ack[0]), 1);
    chk("done_ack_b", 32'(ack[1]), 1);
    chk("done_wr", 32'(wr[0]), 0);
    repeat (15) @(negedge clk);
    chk("done_count_a", qsize(0), 8);
    chk("done_count_b", qsize(1), 6);
    req_ab = 1'b0;
    @(negedge clk);
    chk("done_drop_a", 32'(ack[0]), 0);
    chk("done_drop_b", 32'(ack[1]), 0);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    wq0.delete();
    wq1.delete();
    dat_ab = 32'h0A0B0C0D;
    req_ab = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = wr[0] && data[0] == 8'h0C;
    end
    chk("mid_found", 32'(found), 1);
    reset = 1'b1;
    req_ab = 1'b0;
    @(negedge clk);
    chk("mid_rst_wr", 32'(wr[0]), 0);
    chk("mid_rst_ack", 32'(ack[0]), 0);
    chk("mid_rst_addr", 32'(addr[0]), 0);
    chk("mid_rst_data", 32'(data[0]), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    wq0.delete();
    wq1.delete();
    req_ab = 1'b1;
    @(negedge clk);
    chk("reload_ack", 32'(ack[0]), 1);
    chk("reload_addr", 32'(addr[0]), 0);
    chk("reload_data", 32'(data[0]), 32'h0D);
    repeat (15) @(negedge clk);
    req_ab = 1'b0;
    @(negedge clk);
    chk("reload_drop", 32'(ack[0]), 0);
    chk("reload_count", qsize(0), 4);
    for (int j = 0; j < 4; j++) expect_wr(0, j, j, 'h0D - j, 2);

    for (int j = 0; j < 40; j++) img[j] = 8'($urandom);
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      dat_c = {img[4*i+3], img[4*i+2], img[4*i+1], img[4*i]};
      req_c = 1'b1;
      @(negedge clk);
      wait_ack(2, 1'b1, 40, $sformatf("rnd_ack_%0d", i));
      repeat ($urandom_range(0, 5)) @(negedge clk);
      req_c = 1'b0;
      @(negedge clk);
      wait_ack(2, 1'b0, 5, $sformatf("rnd_rel_%0d", i));
    end
    repeat (40) @(negedge clk);
    chk("rnd_count", qsize(2), 37);
    for (int j = 0; j < 37; j++) expect_wr(2, j, (32'h7FFF0 + j) % (1 << 19), int'(img[j]), 3);
    chk("rnd_init", 32'(init[2]), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
